// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter
//   Shares one byte-level I2C master controller between two requesters that
//   each issue single-byte register reads or writes.
//   Write: START dev+W, reg byte, data byte, STOP.
//   Read : START dev+W, reg byte, RESTART dev+R, one byte NACKed, STOP.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready[1:0]   request handshake, bit i = requester i
//   req_rw, req_dev*, req_reg*, req_wdata*   request payload
//   rsp_valid/rsp_id/rsp_rdata/rsp_err       one-cycle completion report
//   cfg_address, i2c_rw        address and R/W bit for the next (re)start
//   start, restart, stop       one-cycle command pulses to the controller
//   tx_data/tx_valid/tx_ready  byte to the controller
//   rx_data/rx_valid/rx_ready  byte from the controller
//   ack_in                     ack bit returned on the read byte (1 = NACK)
//   ack_out, busy, error       controller status
//   dbg_state                  current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is a single-cycle one-hot grant; tx_valid/tx_data hold
// steady until tx_ready, except that an error from the controller drops
// tx_valid immediately.
module i2c_reg_arbiter #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_rw,
  input  logic [6:0] req_dev0,
  input  logic [6:0] req_dev1,
  input  logic [7:0] req_reg0,
  input  logic [7:0] req_reg1,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [6:0] cfg_address,
  output logic       i2c_rw,
  output logic       start,
  output logic       restart,
  output logic       stop,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       ack_in,
  input  logic       ack_out,
  input  logic       busy,
  input  logic       error,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_TX_REG    = 4'd2,
    S_TX_DATA   = 4'd3,
    S_RESTART   = 4'd4,
    S_RX_DATA   = 4'd5,
    S_STOP      = 4'd6,
    S_WAIT_IDLE = 4'd7,
    S_RESP      = 4'd8
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_last_id;   // requester granted most recently
  logic           r_id;
  logic           r_rw;
  logic [6:0]     r_dev;
  logic [7:0]     r_reg;
  logic [7:0]     r_wdata;
  logic [7:0]     r_rdata;
  logic           r_err;
  logic [1:0]     w_grant;
  logic           w_timeout;
  logic           w_set_err;
  logic           w_counting;
  logic           w_unused;

  // The controller reports NACKs through error, so ack_out carries no
  // additional information here.
  assign w_unused = ack_out;

  // Round-robin between two: requester 0 wins a tie unless it was the last
  // one served. Gated by rst so req_ready is low while reset is held.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE && !busy && !rst) begin
      w_grant[0] = req_valid[0] & (~req_valid[1] | r_last_id);
      w_grant[1] = req_valid[1] & ~w_grant[0];
    end
  end

  assign w_counting = (r_state == S_TX_REG) || (r_state == S_TX_DATA) ||
                      (r_state == S_RX_DATA) || (r_state == S_WAIT_IDLE);
  // The counter holds the number of cycles already spent in the state, so
  // this fires on the TIMEOUT_CYC-th cycle of the wait.
  assign w_timeout  = w_counting && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a controller error outranks a handshake in the same
  // cycle, and a handshake outranks a timeout.
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE:    if (w_grant != 2'b00) w_next = S_START;
      S_START: begin
        if (error) begin w_next = S_STOP; w_set_err = 1'b1; end
        else             w_next = S_TX_REG;
      end
      S_TX_REG: begin
        if (error)          begin w_next = S_STOP; w_set_err = 1'b1; end
        else if (tx_ready)        w_next = r_rw ? S_RESTART : S_TX_DATA;
        else if (w_timeout) begin w_next = S_STOP; w_set_err = 1'b1; end
      end
      S_TX_DATA: begin
        if (error)          begin w_next = S_STOP; w_set_err = 1'b1; end
        else if (tx_ready)        w_next = S_STOP;
        else if (w_timeout) begin w_next = S_STOP; w_set_err = 1'b1; end
      end
      S_RESTART: begin
        if (error) begin w_next = S_STOP; w_set_err = 1'b1; end
        else             w_next = S_RX_DATA;
      end
      S_RX_DATA: begin
        if (error)          begin w_next = S_STOP; w_set_err = 1'b1; end
        else if (rx_valid)        w_next = S_STOP;
        else if (w_timeout) begin w_next = S_STOP; w_set_err = 1'b1; end
      end
      S_STOP:      w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!busy)          w_next = S_RESP;
        else if (w_timeout) begin w_next = S_RESP; w_set_err = 1'b1; end
      end
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = w_grant;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_rdata = 8'h00;
    rsp_err   = 1'b0;
    i2c_rw    = 1'b0;
    start     = 1'b0;
    restart   = 1'b0;
    stop      = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    ack_in    = 1'b0;
    case (r_state)
      S_START:   start = 1'b1;
      S_TX_REG: begin
        tx_data  = r_reg;
        tx_valid = ~error;
      end
      S_TX_DATA: begin
        tx_data  = r_wdata;
        tx_valid = ~error;
      end
      S_RESTART: begin
        i2c_rw  = 1'b1;
        restart = 1'b1;
      end
      S_RX_DATA: begin
        i2c_rw   = 1'b1;
        rx_ready = ~error;
        ack_in   = 1'b1;   // single byte read, so always NACK it
      end
      S_STOP:    stop = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_rdata = r_err ? 8'h00 : r_rdata;
        rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  assign cfg_address = r_dev;
  assign dbg_state   = r_state;

  // Wait counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_counting)        r_cnt <= r_cnt + 1'b1;
  end

  // Transaction context, captured once at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_rw      <= 1'b0;
      r_dev     <= 7'h00;
      r_reg     <= 8'h00;
      r_wdata   <= 8'h00;
      r_rdata   <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      if (w_grant != 2'b00) begin
        r_last_id <= w_grant[1];
        r_id      <= w_grant[1];
        r_rw      <= w_grant[1] ? req_rw[1]  : req_rw[0];
        r_dev     <= w_grant[1] ? req_dev1   : req_dev0;
        r_reg     <= w_grant[1] ? req_reg1   : req_reg0;
        r_wdata   <= w_grant[1] ? req_wdata1 : req_wdata0;
        r_rdata   <= 8'h00;
        r_err     <= 1'b0;
      end
      if (r_state == S_RX_DATA && rx_valid && !error) r_rdata <= rx_data;
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
module tb_i2c_reg_arbiter;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_TX_REG  = 4'd2;
  localparam logic [3:0] S_RX_DATA = 4'd5;
  localparam logic [3:0] S_NONE    = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, req_rw;
  logic [6:0] req_dev0, req_dev1;
  logic [7:0] req_reg0, req_reg1, req_wdata0, req_wdata1;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_rdata;
  logic [6:0] cfg_address;
  logic       i2c_rw, start, restart, stop;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       ack_in, ack_out, busy, error;
  logic [3:0] dbg_state;

  i2c_reg_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev0(req_dev0), .req_dev1(req_dev1),
    .req_reg0(req_reg0), .req_reg1(req_reg1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_address(cfg_address), .i2c_rw(i2c_rw),
    .start(start), .restart(restart), .stop(stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ack_in(ack_in), .ack_out(ack_out), .busy(busy), .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / recorder ----------------
  logic [7:0] exp_q[$];      // bytes expected on the tx handshake, in order
  logic [6:0] exp_dev;
  logic [7:0] rx_model;
  bit         no_tx_ready, hold_busy, err_in_txreg, busy_on;
  int         n_start, n_restart, n_stop, n_grant, n_rx;
  int         last_grant, txreg_cyc, stop_cyc, rsp_cyc;
  bit         rsp_seen;
  logic       rsp_id_s, rsp_err_s;
  logic [7:0] rsp_rdata_s;

  function automatic logic [63:0] all_outs();
    return {29'd0, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, cfg_address,
            i2c_rw, start, restart, stop, tx_data, tx_valid, rx_ready, ack_in};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00; req_rw = 2'b00;
    req_dev0 = 7'h00; req_dev1 = 7'h00; req_reg0 = 8'h00; req_reg1 = 8'h00;
    req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    ack_out = 1'b0; busy = 1'b0; error = 1'b0; busy_on = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", all_outs(), 64'd0);
    check("rst_state", {60'd0, dbg_state}, {60'd0, S_IDLE});
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd);
    if (id == 0) begin
      req_rw[0] = rw; req_dev0 = dev; req_reg0 = rg; req_wdata0 = wd;
    end else begin
      req_rw[1] = rw; req_dev1 = dev; req_reg1 = rg; req_wdata1 = wd;
    end
    req_valid[id] = 1'b1;
  endtask

  // Plays requester and controller for one transaction. Stops on the
  // response, on reaching state stop_at, or when the budget runs out.
  task automatic run(input int budget, input logic [3:0] stop_at);
    int  cyc;
    int  gid;
    n_start = 0; n_restart = 0; n_stop = 0; n_grant = 0; n_rx = 0;
    last_grant = -1; txreg_cyc = -1; stop_cyc = -1; rsp_cyc = -1;
    rsp_seen = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      if (stop_at != S_NONE && dbg_state == stop_at) break;
      busy  = busy_on;
      error = err_in_txreg && (dbg_state == S_TX_REG);
      #1;
      tx_ready = no_tx_ready ? 1'b0 : tx_valid;
      rx_valid = rx_ready;
      rx_data  = rx_valid ? rx_model : 8'h00;
      #1;
      gid = -1;
      if (req_ready != 2'b00) begin
        n_grant++;
        gid = req_ready[1] ? 1 : 0;
        last_grant = gid;
        check("grant_onehot", {62'd0, req_ready}, gid == 1 ? 64'd2 : 64'd1);
      end
      if (dbg_state == S_TX_REG && txreg_cyc < 0) txreg_cyc = cyc;
      if (error) check("err_drops_txv", {63'd0, tx_valid}, 64'd0);
      if (start) begin
        n_start++;
        check("start_addr", {57'd0, cfg_address}, {57'd0, exp_dev});
        check("start_rw", {63'd0, i2c_rw}, 64'd0);
        busy_on = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_extra", {56'd0, tx_data}, 64'hFFFF);
        else check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
      end
      if (restart) begin
        n_restart++;
        check("restart_rw", {63'd0, i2c_rw}, 64'd1);
      end
      if (rx_ready && rx_valid) begin
        n_rx++;
        check("rx_nack", {63'd0, ack_in}, 64'd1);
      end
      if (stop) begin
        n_stop++;
        stop_cyc = cyc;
        if (!hold_busy) busy_on = 1'b0;
      end
      if (rsp_valid) begin
        rsp_seen = 1'b1; rsp_cyc = cyc;
        rsp_id_s = rsp_id; rsp_rdata_s = rsp_rdata; rsp_err_s = rsp_err;
        busy_on = 1'b0;
        if (req_valid != 2'b00) check("no_grant_in_resp", {62'd0, req_ready}, 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
      if (gid >= 0) req_valid[gid] = 1'b0;
      if (rsp_seen) break;
    end
    tx_ready = 1'b0; rx_valid = 1'b0; error = 1'b0; busy = busy_on;
    if (stop_at == S_NONE && !rsp_seen)
      check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_done(input int gnt, input logic id, input logic [7:0] rd,
                             input logic err, input int n_rs);
    check("rsp_seen", {63'd0, rsp_seen}, 64'd1);
    check("grant_id", 64'(last_grant), 64'(gnt));
    check("grant_cnt", 64'(n_grant), 64'd1);
    check("rsp_id", {63'd0, rsp_id_s}, {63'd0, id});
    check("rsp_rdata", {56'd0, rsp_rdata_s}, {56'd0, rd});
    check("rsp_err", {63'd0, rsp_err_s}, {63'd0, err});
    check("start_cnt", 64'(n_start), 64'd1);
    check("restart_cnt", 64'(n_restart), 64'(n_rs));
    check("stop_cnt", 64'(n_stop), 64'd1);
    check("txq_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit any_rsp;
    no_tx_ready = 0; hold_busy = 0; err_in_txreg = 0; rx_model = 8'h00;
    do_reset();

    // Register write from requester 0
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    exp_dev = 7'h50; exp_q.push_back(8'h10); exp_q.push_back(8'hA5);
    run(100, S_NONE);
    expect_done(0, 1'b0, 8'h00, 1'b0, 0);
    check("wr_stop_to_rsp", 64'(rsp_cyc - stop_cyc), 64'd2);
    check("idle_after_rsp", {60'd0, dbg_state}, {60'd0, S_IDLE});

    // Register read from requester 1
    set_req(1, 1'b1, 7'h50, 8'h20, 8'h00);
    rx_model = 8'h3C;
    exp_dev = 7'h50; exp_q.push_back(8'h20);
    run(100, S_NONE);
    expect_done(1, 1'b1, 8'h3C, 1'b0, 1);
    check("rd_rx_cnt", 64'(n_rx), 64'd1);

    // Contention from reset: 0, then 1, then 0 again
    do_reset();
    set_req(0, 1'b0, 7'h51, 8'h11, 8'h22);
    set_req(1, 1'b0, 7'h52, 8'h33, 8'h44);
    exp_dev = 7'h51; exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    run(100, S_NONE);
    expect_done(0, 1'b0, 8'h00, 1'b0, 0);
    exp_dev = 7'h52; exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    run(100, S_NONE);
    expect_done(1, 1'b1, 8'h00, 1'b0, 0);
    set_req(0, 1'b0, 7'h51, 8'h55, 8'h66);
    set_req(1, 1'b0, 7'h52, 8'h77, 8'h88);
    exp_dev = 7'h51; exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    run(100, S_NONE);
    expect_done(0, 1'b0, 8'h00, 1'b0, 0);
    exp_dev = 7'h52; exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    run(100, S_NONE);
    expect_done(1, 1'b1, 8'h00, 1'b0, 0);

    // Controller error while the register byte is offered
    err_in_txreg = 1;
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    exp_dev = 7'h50;
    run(100, S_NONE);
    err_in_txreg = 0;
    expect_done(0, 1'b0, 8'h00, 1'b1, 0);
    check("err_stop_delay", 64'(stop_cyc - txreg_cyc), 64'd1);

    // tx_ready never comes: abort after 16 cycles in TX_REG (read that
    // would otherwise return data)
    no_tx_ready = 1;
    rx_model = 8'h99;
    set_req(1, 1'b1, 7'h50, 8'h20, 8'h00);
    run(100, S_NONE);
    no_tx_ready = 0;
    expect_done(1, 1'b1, 8'h00, 1'b1, 0);
    check("tmo_txreg_cycles", 64'(stop_cyc - txreg_cyc), 64'd16);

    // busy stuck after stop: WAIT_IDLE gives up after 16 cycles
    hold_busy = 1;
    set_req(0, 1'b0, 7'h50, 8'h12, 8'h34);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    run(100, S_NONE);
    hold_busy = 0;
    expect_done(0, 1'b0, 8'h00, 1'b1, 0);
    check("tmo_wait_cycles", 64'(rsp_cyc - stop_cyc), 64'd17);

    // Reset in the middle of RX_DATA
    rx_model = 8'h5A;
    set_req(0, 1'b1, 7'h50, 8'h40, 8'h00);
    exp_q.push_back(8'h40);
    run(100, S_RX_DATA);
    check("mid_rx_state", {60'd0, dbg_state}, {60'd0, S_RX_DATA});
    check("mid_rx_ready", {63'd0, rx_ready}, 64'd1);
    rst = 1'b1; busy_on = 1'b0; busy = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    check("rst_edge_outs", all_outs(), 64'd0);
    check("rst_edge_state", {60'd0, dbg_state}, {60'd0, S_IDLE});
    rst = 1'b0;
    exp_q.delete();
    any_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || stop) any_rsp = 1;
    end
    check("no_rsp_after_rst", {63'd0, any_rsp}, 64'd0);

    // Priority back to requester 0 after reset, service resumes normally
    set_req(0, 1'b0, 7'h51, 8'hC0, 8'hC1);
    set_req(1, 1'b0, 7'h52, 8'hD0, 8'hD1);
    exp_dev = 7'h51; exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    run(100, S_NONE);
    expect_done(0, 1'b0, 8'h00, 1'b0, 0);
    exp_dev = 7'h52; exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
    run(100, S_NONE);
    expect_done(1, 1'b1, 8'h00, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
